// File: rtl/filter2d_rd_sched_if.sv
// Read-scheduler bus: frame control, buffer read port and tagged tap stream.
interface filter2d_rd_sched_if #(parameter int AW = 16);
  logic          start;
  logic          i_ready;
  logic          mem_rd;
  logic [AW-1:0] rd_addr;
  logic [7:0]    rd_data;
  logic          o_valid;
  logic [7:0]    o_data;
  logic [3:0]    o_tap;
  logic          o_last;
  logic          o_eof;
  logic          o_busy;
  logic          o_done;
  logic          o_overrun;

  modport master (
    input  start, i_ready, rd_data,
    output mem_rd, rd_addr, o_valid, o_data, o_tap, o_last, o_eof,
           o_busy, o_done, o_overrun
  );

  modport slave (
    output start, i_ready, rd_data,
    input  mem_rd, rd_addr, o_valid, o_data, o_tap, o_last, o_eof,
           o_busy, o_done, o_overrun
  );
endinterface

// File: rtl/filter2d_rd_sched.sv
// 3x3 raster tap scheduler; tap out 2 cycles after its read slot, i_ready gates issue only (output never stalls).
// FILTER2D_ZERO_PAD_EN selects zero padding of border taps; undefined gives edge replication.
module filter2d_rd_sched #(
  parameter int W_LOG2 = 8,
  parameter int H_LOG2 = 8,
  parameter int AW     = W_LOG2 + H_LOG2
) (
  input  logic                clk,
  input  logic                reset,
  filter2d_rd_sched_if.master bus
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  localparam logic signed [1:0] KM1 = -2'sd1;
  localparam logic signed [1:0] KP1 = 2'sd1;

  state_t state, state_nxt;
  logic   issue;

  logic [W_LOG2-1:0] x;
  logic [H_LOG2-1:0] y;
  logic signed [1:0] kx, ky;

  logic              last_tap, last_of_win;
  logic              oob_x, oob_y;
  logic [W_LOG2-1:0] kx_ext, tx_raw, tx;
  logic [H_LOG2-1:0] ky_ext, ty_raw, ty;
  logic [1:0]        kxi, kyi;
  logic [3:0]        tap_idx;
  logic              rd_en, pad;

  // issue register (read slot) and one tag stage aligned with rd_data
  logic       iss_vld, iss_last, iss_eof, iss_pad;
  logic [3:0] iss_tap;
  logic       s1_vld, s1_last, s1_eof, s1_pad;
  logic [3:0] s1_tap;

  assign last_of_win = (kx == KP1) && (ky == KP1);
  assign last_tap    = last_of_win && (x == '1) && (y == '1);

  assign kx_ext = {{(W_LOG2-1){kx[1]}}, kx[0]};
  assign ky_ext = {{(H_LOG2-1){ky[1]}}, ky[0]};
  assign tx_raw = x + kx_ext;
  assign ty_raw = y + ky_ext;

  assign oob_x = ((x == '0) && (kx == KM1)) || ((x == '1) && (kx == KP1));
  assign oob_y = ((y == '0) && (ky == KM1)) || ((y == '1) && (ky == KP1));

`ifdef FILTER2D_ZERO_PAD_EN
  assign tx    = tx_raw;
  assign ty    = ty_raw;
  assign pad   = oob_x || oob_y;
  assign rd_en = !pad;
`else
  assign tx    = oob_x ? x : tx_raw;
  assign ty    = oob_y ? y : ty_raw;
  assign pad   = 1'b0;
  assign rd_en = 1'b1;
`endif

  assign kxi     = kx + 2'd1;
  assign kyi     = ky + 2'd1;
  assign tap_idx = {2'b00, kyi} * 4'd3 + {2'b00, kxi};

  assign bus.o_busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    case (state)
      IDLE:  if (bus.start) state_nxt = RUN;
      RUN: begin
        issue = bus.i_ready;
        if (issue && last_tap) state_nxt = DRAIN;
      end
      DRAIN: if (bus.o_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset || (state == IDLE && bus.start)) begin
      x  <= '0;
      y  <= '0;
      kx <= KM1;
      ky <= KM1;
    end else if (issue && !last_tap) begin
      if (kx != KP1) begin
        kx <= kx + 2'sd1;
      end else begin
        kx <= KM1;
        if (ky != KP1) begin
          ky <= ky + 2'sd1;
        end else begin
          ky <= KM1;
          if (x != '1) begin
            x <= x + 1'b1;
          end else begin
            x <= '0;
            y <= y + 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.mem_rd    <= 1'b0;
      bus.rd_addr   <= '0;
      iss_vld       <= 1'b0;
      iss_tap       <= '0;
      iss_last      <= 1'b0;
      iss_eof       <= 1'b0;
      iss_pad       <= 1'b0;
      s1_vld        <= 1'b0;
      s1_tap        <= '0;
      s1_last       <= 1'b0;
      s1_eof        <= 1'b0;
      s1_pad        <= 1'b0;
      bus.o_valid   <= 1'b0;
      bus.o_data    <= '0;
      bus.o_tap     <= '0;
      bus.o_last    <= 1'b0;
      bus.o_eof     <= 1'b0;
      bus.o_done    <= 1'b0;
      bus.o_overrun <= 1'b0;
    end else begin
      bus.mem_rd <= issue && rd_en;
      if (issue) bus.rd_addr <= AW'({ty, tx});
      iss_vld  <= issue;
      iss_tap  <= issue ? tap_idx : 4'd0;
      iss_last <= issue && last_of_win;
      iss_eof  <= issue && last_tap;
      iss_pad  <= issue && pad;

      s1_vld  <= iss_vld;
      s1_tap  <= iss_tap;
      s1_last <= iss_last;
      s1_eof  <= iss_eof;
      s1_pad  <= iss_pad;

      // rd_data is valid only in the stage-1 cycle, so it is captured here
      bus.o_valid <= s1_vld;
      bus.o_data  <= (s1_vld && !s1_pad) ? bus.rd_data : 8'd0;
      bus.o_tap   <= s1_tap;
      bus.o_last  <= s1_last;
      bus.o_eof   <= s1_eof;

      bus.o_done    <= (state == DRAIN) && bus.o_valid && bus.o_eof;
      bus.o_overrun <= bus.start && (state != IDLE);
    end
  end

endmodule

// File: tb/tb_filter2d_rd_sched.sv
// Scoreboard bench for filter2d_rd_sched on a 4x4 image with mem[a] = a + 16.
module tb_filter2d_rd_sched;
  localparam int W_LOG2 = 2;
  localparam int H_LOG2 = 2;
  localparam int AW     = 4;
  localparam int W      = 4;
  localparam int H      = 4;

  typedef struct {
    int d;
    int t;
    int l;
    int e;
  } tap_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  filter2d_rd_sched_if #(.AW(AW)) bus();

  filter2d_rd_sched #(.W_LOG2(W_LOG2), .H_LOG2(H_LOG2), .AW(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // buffer model: one-cycle read latency, garbage when not reading
  always @(posedge clk)
    bus.rd_data <= bus.mem_rd ? (8'(bus.rd_addr) + 8'd16) : 8'hEE;

  tap_t exp_q[$];
  int   addr_q[$];
  int   nvec = 0;
  int   nerr = 0;
  int   tap_cnt = 0;
  int   done_cnt = 0;
  int   ovr_cnt = 0;
  int   mode = 0;

  task automatic chk(string nm, int act, int exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // reference: enumerate every tap of the frame straight from the raster rules
  function automatic void push_frame();
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        for (int ky = -1; ky <= 1; ky++)
          for (int kx = -1; kx <= 1; kx++) begin
            tap_t e;
            int cx, cy;
            bit inr;
            cx  = x + kx;
            cy  = y + ky;
            inr = (cx >= 0) && (cx < W) && (cy >= 0) && (cy < H);
`ifdef FILTER2D_ZERO_PAD_EN
            if (inr) addr_q.push_back(cy * W + cx);
            e.d = inr ? (cy * W + cx + 16) : 0;
`else
            if (cx < 0) cx = 0;
            if (cx > W - 1) cx = W - 1;
            if (cy < 0) cy = 0;
            if (cy > H - 1) cy = H - 1;
            addr_q.push_back(cy * W + cx);
            e.d = cy * W + cx + 16;
`endif
            e.t = (ky + 1) * 3 + (kx + 1);
            e.l = (e.t == 8) ? 1 : 0;
            e.e = (e.t == 8 && x == W - 1 && y == H - 1) ? 1 : 0;
            exp_q.push_back(e);
          end
  endfunction

  // monitor: samples 1 time unit after each rising edge
  int mr1 = 0, mr2 = 0, eof_prev = 0;
  always @(posedge clk) begin
    #1;
    if (reset) begin
      mr1 = 0;
      mr2 = 0;
      eof_prev = 0;
    end else begin
      if (bus.mem_rd) begin
        chk("rd_after_ready", int'(bus.i_ready), 1);
        if (addr_q.size() == 0) chk("unexpected_rd", 1, 0);
        else chk("rd_addr", int'(bus.rd_addr), addr_q.pop_front());
      end
      if (bus.o_valid) begin
        tap_cnt++;
        if (exp_q.size() == 0) begin
          chk("unexpected_tap", 1, 0);
        end else begin
          tap_t e;
          e = exp_q.pop_front();
          chk("o_data", int'(bus.o_data), e.d);
          chk("o_tap", int'(bus.o_tap), e.t);
          chk("o_last", int'(bus.o_last), e.l);
          chk("o_eof", int'(bus.o_eof), e.e);
        end
      end
      if (bus.o_done || eof_prev != 0) chk("done_after_eof", int'(bus.o_done), eof_prev);
`ifndef FILTER2D_ZERO_PAD_EN
      if (bus.o_valid || mr2 != 0) chk("tap_latency", int'(bus.o_valid), mr2);
`endif
      done_cnt += int'(bus.o_done);
      ovr_cnt  += int'(bus.o_overrun);
      mr2 = mr1;
      mr1 = int'(bus.mem_rd);
      eof_prev = int'(bus.o_valid && bus.o_eof);
    end
  end

  // consumer throttle: 0 always ready, 1 alternating, 2 random
  initial begin
    bus.i_ready = 1'b0;
    forever begin
      @(negedge clk);
      case (mode)
        0:       bus.i_ready = 1'b1;
        1:       bus.i_ready = ~bus.i_ready;
        default: bus.i_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  task automatic chk_quiet(string pfx);
    chk({pfx, "_mem_rd"},  int'(bus.mem_rd), 0);
    chk({pfx, "_rd_addr"}, int'(bus.rd_addr), 0);
    chk({pfx, "_o_valid"}, int'(bus.o_valid), 0);
    chk({pfx, "_o_data"},  int'(bus.o_data), 0);
    chk({pfx, "_o_tap"},   int'(bus.o_tap), 0);
    chk({pfx, "_o_last"},  int'(bus.o_last), 0);
    chk({pfx, "_o_eof"},   int'(bus.o_eof), 0);
    chk({pfx, "_o_busy"},  int'(bus.o_busy), 0);
    chk({pfx, "_o_done"},  int'(bus.o_done), 0);
    chk({pfx, "_o_overrun"}, int'(bus.o_overrun), 0);
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int d0);
    for (int i = 0; i < 3000 && done_cnt == d0; i++) @(negedge clk);
    chk("frame_done_seen", (done_cnt > d0) ? 1 : 0, 1);
    repeat (5) @(negedge clk);
  endtask

  task automatic run_frame(input int m, input int ovr_at);
    int d0, t0, o0;
    mode = m;
    d0 = done_cnt;
    t0 = tap_cnt;
    o0 = ovr_cnt;
    push_frame();
    @(negedge clk);
    pulse_start();
    @(negedge clk);
    chk("busy_in_frame", int'(bus.o_busy), 1);
    if (ovr_at > 0) begin
      repeat (ovr_at) @(negedge clk);
      pulse_start();
    end
    wait_done(d0);
    chk("done_count", done_cnt - d0, 1);
    chk("tap_count", tap_cnt - t0, W * H * 9);
    chk("overrun_count", ovr_cnt - o0, (ovr_at > 0) ? 1 : 0);
    chk("exp_left", exp_q.size(), 0);
    chk("addr_left", addr_q.size(), 0);
    chk("idle_after_frame", int'(bus.o_busy), 0);
  endtask

  initial begin
    int d0, t0;
    bus.start = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk_quiet("reset");
    reset = 1'b0;
    repeat (2) @(negedge clk);

    run_frame(0, 0);
    run_frame(1, 0);
    run_frame(2, 0);
    run_frame(0, 20);

    // reset mid-frame: in-flight taps must vanish
    mode = 0;
    d0 = done_cnt;
    push_frame();
    @(negedge clk);
    pulse_start();
    repeat (50) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    exp_q.delete();
    addr_q.delete();
    @(negedge clk);
    chk_quiet("midreset");
    reset = 1'b0;
    t0 = tap_cnt;
    repeat (20) @(negedge clk);
    chk("no_stale_taps", tap_cnt - t0, 0);
    chk("no_stale_done", done_cnt - d0, 0);
    chk("idle_after_reset", int'(bus.o_busy), 0);
    run_frame(0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
